uart_rx_stream: RTL and testbench

UART_RX_STREAM -- requirements
Module: uart_rx_stream

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx_stream.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receive stream.
// Optional even-parity support is enabled by defining UART_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO for received UART data; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic                 wr_en;
    logic                 rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A write while full is allowed when the head leaves in the same clock.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_stream.sv
// 16x oversampling UART receiver feeding a ready/valid byte stream.
// Define UART_PARITY_EN to receive one even-parity bit before the stop bit.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 326,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serialInput,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       frameError,
    output logic       overrun,
    output logic       parityError
);

    logic        sync_0;
    logic        sync_1;
    logic        line;
    logic [15:0] tick_cnt;
    logic        sample_tick;

    rx_state_t   state, state_n;
    logic [3:0]  sample_cnt, sample_cnt_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift_reg, shift_n;
    logic        armed, armed_n;
    logic        push_req;
    logic        frame_err_set;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b1;
            sync_1 <= 1'b1;
        end else begin
            sync_0 <= serialInput;
            sync_1 <= sync_0;
        end
    end

    assign line = sync_1;

    assign sample_tick = (tick_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            tick_cnt <= '0;
        else if (sample_tick) tick_cnt <= '0;
        else                  tick_cnt <= tick_cnt + 16'd1;
    end

`ifdef UART_PARITY_EN
    logic parity_bad, parity_bad_n;
    logic parity_err_set;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            armed      <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_n;
            armed      <= armed_n;
`ifdef UART_PARITY_EN
            parity_bad <= parity_bad_n;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        sample_cnt_n  = sample_cnt;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift_reg;
        armed_n       = armed;
        push_req      = 1'b0;
        frame_err_set = 1'b0;
`ifdef UART_PARITY_EN
        parity_bad_n   = parity_bad;
        parity_err_set = 1'b0;
`endif
        if (sample_tick) begin
            unique case (state)
                ST_IDLE: begin
                    // A break that ended in a frame error must see the line high before re-arming.
                    if (line) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n      = ST_START;
                        sample_cnt_n = '0;
`ifdef UART_PARITY_EN
                        parity_bad_n = 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (sample_cnt == MID_SAMPLE) begin
                        if (line) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n      = ST_DATA;
                            sample_cnt_n = '0;
                            bit_cnt_n    = '0;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (sample_cnt == LAST_SAMPLE) begin
                        shift_n      = {line, shift_reg[7:1]};
                        sample_cnt_n = '0;
                        bit_cnt_n    = bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (sample_cnt == LAST_SAMPLE) begin
                        parity_bad_n   = (^shift_reg) ^ line;
                        parity_err_set = (^shift_reg) ^ line;
                        state_n        = ST_STOP;
                        sample_cnt_n   = '0;
                    end else begin
                        sample_cnt_n = sample_cnt + 4'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_cnt == LAST_SAMPLE) begin
                        if (line) begin
`ifdef UART_PARITY_EN
                            push_req = !parity_bad;
`else
                            push_req = 1'b1;
`endif
                        end else begin
                            frame_err_set = 1'b1;
                            armed_n       = 1'b0;
                        end
                        state_n      = ST_IDLE;
                        sample_cnt_n = '0;
                    end else begin
                        sample_cnt_n = sample_cnt + 4'd1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign pop     = rxValid && rxReady;
    assign rxValid = !fifo_empty;

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (shift_reg),
        .dout  (rxData),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frameError <= frame_err_set;
            overrun    <= push_req && fifo_full && !pop;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parityError <= 1'b0;
        else       parityError <= parity_err_set;
    end
`else
    assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream with CLK_DIV=4 (64 clocks per bit).
// Parity scenario is included only when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_stream;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CLKS = CLK_DIV * 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serialInput = 1'b1;
    logic       rxReady = 1'b1;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameError;
    logic       overrun;
    logic       parityError;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, beat_cnt = 0;
    int rise_cyc = -1000;
    int stop_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q [$];

`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_stream #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serialInput (serialInput),
        .rxData      (rxData),
        .rxValid     (rxValid),
        .rxReady     (rxReady),
        .frameError  (frameError),
        .overrun     (overrun),
        .parityError (parityError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and compares every accepted byte against the queue.
    always @(negedge clk) begin
        if (rxValid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = (rxValid === 1'b1);
        if (frameError === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (parityError === 1'b1) pe_cnt++;
        if (rxValid === 1'b1 && rxReady === 1'b1) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_unexpected: got 0x%0h, required no byte", rxData);
            end else begin
                check("rx_data", {24'd0, rxData}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic expect_push);
        if (expect_push) exp_q.push_back(d);
        serialInput = 1'b0;
        tick_n(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            serialInput = d[i];
            tick_n(BIT_CLKS);
        end
`ifdef UART_PARITY_EN
        serialInput = (^d) ^ par_flip;
        tick_n(BIT_CLKS);
`endif
        stop_cyc = cyc;
        serialInput = stop_b;
        tick_n(BIT_CLKS);
        serialInput = 1'b1;
        tick_n(2 * BIT_CLKS);
    endtask

    int fe0, ov0, pe0, b0, lat;

    initial begin
        reset = 1'b1;
        tick_n(5);
        @(negedge clk);
        check("reset_rxValid", {31'd0, rxValid}, 32'd0);
        check("reset_rxData", {24'd0, rxData}, 32'd0);
        check("reset_frameError", {31'd0, frameError}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_parityError", {31'd0, parityError}, 32'd0);
        tick_n(1);
        reset = 1'b0;
        tick_n(2 * BIT_CLKS);

        // Good frame 0xA5
        fe0 = fe_cnt; ov0 = ov_cnt; b0 = beat_cnt; rise_cyc = -1000;
        send_frame(8'hA5, 1'b1, 1'b1);
        lat = rise_cyc - stop_cyc;
        check("a5_valid_latency_in_window", {31'd0, (lat >= 33 && lat <= 40)}, 32'd1);
        check("a5_beats", beat_cnt - b0, 1);
        check("a5_frameError", fe_cnt - fe0, 0);
        check("a5_overrun", ov_cnt - ov0, 0);

        // Short low glitch is rejected
        fe0 = fe_cnt; ov0 = ov_cnt; b0 = beat_cnt;
        serialInput = 1'b0;
        tick_n(16);
        serialInput = 1'b1;
        tick_n(4 * BIT_CLKS);
        check("glitch_beats", beat_cnt - b0, 0);
        check("glitch_frameError", fe_cnt - fe0, 0);
        check("glitch_overrun", ov_cnt - ov0, 0);

        // Bad stop bit, then recovery
        fe0 = fe_cnt; b0 = beat_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        check("badstop_frameError", fe_cnt - fe0, 1);
        check("badstop_beats", beat_cnt - b0, 0);
        send_frame(8'h11, 1'b1, 1'b1);
        check("after_badstop_beats", beat_cnt - b0, 1);

        // Break: exactly one frame error
        fe0 = fe_cnt; b0 = beat_cnt;
        serialInput = 1'b0;
        tick_n(30 * BIT_CLKS);
        serialInput = 1'b1;
        tick_n(3 * BIT_CLKS);
        check("break_frameError", fe_cnt - fe0, 1);
        check("break_beats", beat_cnt - b0, 0);

        // Overrun with FIFO_DEPTH=4
        ov0 = ov_cnt; b0 = beat_cnt;
        rxReady = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b1);
        check("fill_overrun", ov_cnt - ov0, 0);
        send_frame(8'h05, 1'b1, 1'b0);
        check("full_overrun", ov_cnt - ov0, 1);
        @(negedge clk);
        check("full_rxValid", {31'd0, rxValid}, 32'd1);
        check("full_head", {24'd0, rxData}, 32'h01);
        tick_n(1);
        rxReady = 1'b1;
        tick_n(10);
        @(negedge clk);
        check("drain_beats", beat_cnt - b0, 4);
        check("drain_rxValid", {31'd0, rxValid}, 32'd0);
        tick_n(1);

`ifdef UART_PARITY_EN
        pe0 = pe_cnt; b0 = beat_cnt;
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1, 1'b0);
        par_flip = 1'b0;
        check("parity_bad_pulse", pe_cnt - pe0, 1);
        check("parity_bad_beats", beat_cnt - b0, 0);
        send_frame(8'h03, 1'b1, 1'b1);
        check("parity_good_pulse", pe_cnt - pe0, 1);
        check("parity_good_beats", beat_cnt - b0, 1);
`endif

        // Reset during data bit 4 of 0xFF with a byte waiting in the FIFO
        rxReady = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        @(negedge clk);
        check("prereset_rxValid", {31'd0, rxValid}, 32'd1);
        tick_n(1);
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; b0 = beat_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                tick_n(5 * BIT_CLKS + 20);
                reset = 1'b1;
                @(negedge clk);
                check("midreset_rxValid", {31'd0, rxValid}, 32'd0);
                check("midreset_rxData", {24'd0, rxData}, 32'd0);
                check("midreset_pulses", {29'd0, frameError, overrun, parityError}, 32'd0);
                tick_n(3);
                reset = 1'b0;
                rxReady = 1'b1;
            end
        join
        send_frame(8'h5A, 1'b1, 1'b1);
        check("postreset_beats", beat_cnt - b0, 1);
        check("postreset_frameError", fe_cnt - fe0, 0);
        check("postreset_overrun", ov_cnt - ov0, 0);
        check("postreset_parityError", pe_cnt - pe0, 0);

`ifndef UART_PARITY_EN
        check("parityError_never", pe_cnt, 0);
`endif
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
